// File: rtl/pipe_host_ctrl.sv
// pipe_host_ctrl: host front-end that loads/reads the pipeline register file and runs the pipeline to a halt PC or a cycle limit.
// Latency: a write occupies one WRITE cycle; read data is valid (host_rvalid) 2 cycles after acceptance; done pulses 1 cycle after 4 drain cycles.
// Backpressure: host_ready is high only in IDLE; host_valid while busy is ignored and nothing is queued.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   host_valid/host_cmd/host_addr/host_wdata  host command (00 nop, 01 write, 10 run, 11 read)
//   host_ready                    controller idle and able to take a command
//   host_rdata/host_rvalid        read-back data and its one-cycle valid pulse
//   run_limit, halt_pc, cpu_pc    run termination controls and current pipeline fetch PC
//   cpu_en                        pipeline enable (RUN and DRAIN only)
//   wb_rd/wb_data                 pipeline writeback, forwarded to the register file during a run
//   rf_we/rf_waddr/rf_wdata       register-file write port
//   rf_raddr/rf_rdata             register-file read port (rf_rdata combinational from rf_raddr)
//   done, timeout, cycles         run completion pulse, sticky limit flag, enabled-cycle count
module pipe_host_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  input  logic [1:0]  host_cmd,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ready,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  input  logic [15:0] run_limit,
  input  logic [31:0] halt_pc,
  input  logic [31:0] cpu_pc,
  output logic        cpu_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Number of cycles the pipeline keeps running after the halt/limit
  // decision so in-flight instructions can retire their writebacks.
  localparam logic [2:0] DRAIN_CYCLES = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RUN,
    S_DRAIN,
    S_READ,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0]  addr_q;      // register index latched at write/read acceptance
  logic [31:0] wdata_q;     // write data latched at write acceptance
  logic [2:0]  drain_cnt;

  logic accept;
  logic halt_hit;
  logic limit_hit;
  logic run_end;
  logic drain_last;

  assign accept   = host_valid && host_ready;
  assign halt_hit = (cpu_pc == halt_pc);

  // Compare in 17 bits so a saturated count can never wrap onto a small limit.
  assign limit_hit  = (run_limit != 16'd0) &&
                      (({1'b0, cycles} + 17'd1) == {1'b0, run_limit});
  assign run_end    = halt_hit || limit_hit;
  assign drain_last = (drain_cnt == 3'd1);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (host_cmd)
            CMD_NOP:   state_nxt = S_IDLE;
            CMD_WRITE: state_nxt = S_WRITE;
            CMD_RUN:   state_nxt = S_RUN;
            CMD_READ:  state_nxt = S_READ;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_RUN: begin
        if (run_end) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          state_nxt = S_IDLE;
        end
      end
      S_READ:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic (all Moore on state plus pass-through of the writeback bus)
  // ---------------------------------------------------------------------
  always_comb begin
    host_ready  = 1'b0;
    host_rvalid = 1'b0;
    cpu_en      = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    rf_raddr    = 5'd0;
    case (state)
      S_IDLE: begin
        host_ready = 1'b1;
      end
      S_WRITE: begin
        // r0 is architecturally zero, so a host write to it is dropped.
        rf_we    = (addr_q != 5'd0);
        rf_waddr = addr_q;
        rf_wdata = wdata_q;
      end
      S_RUN, S_DRAIN: begin
        cpu_en   = 1'b1;
        rf_we    = (wb_rd != 5'd0);
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end
      S_READ: begin
        rf_raddr = addr_q;
      end
      S_RESP: begin
        host_rvalid = 1'b1;
      end
      default: begin
        host_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers: command latches, run counters, status, read data
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 5'd0;
      wdata_q    <= 32'd0;
      drain_cnt  <= 3'd0;
      cycles     <= 16'd0;
      timeout    <= 1'b0;
      done       <= 1'b0;
      host_rdata <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if ((host_cmd == CMD_WRITE) || (host_cmd == CMD_READ)) begin
              addr_q <= host_addr;
            end
            if (host_cmd == CMD_WRITE) begin
              wdata_q <= host_wdata;
            end
            if (host_cmd == CMD_RUN) begin
              cycles  <= 16'd0;
              timeout <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (cycles != 16'hFFFF) begin
            cycles <= cycles + 16'd1;
          end
          if (run_end) begin
            drain_cnt <= DRAIN_CYCLES;
          end
          // A halt in the same cycle wins: the run ended normally.
          if (limit_hit && !halt_hit) begin
            timeout <= 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_last) begin
            done <= 1'b1;
          end
        end
        S_READ: begin
          host_rdata <= rf_rdata;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_host_ctrl.md
PIPE_HOST_CTRL -- requirements
Module: pipe_host_ctrl

Interface
REQ-001 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- host_valid  in  1  host command valid
- host_cmd  in  2  command: 00 nop, 01 reg write, 10 run, 11 reg read
- host_addr  in  5  register index for write/read
- host_wdata  in  32  write data
- host_ready  out  1  controller can accept a command
- host_rdata  out  32  read-back data
- host_rvalid  out  1  read-back data valid, one-cycle pulse
- run_limit  in  16  maximum run cycles; 0 means unlimited
- halt_pc  in  32  PC value that ends a run
- cpu_pc  in  32  current fetch PC of the pipeline
- cpu_en  out  1  pipeline enable
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- rf_raddr  out  5  register-file read address
- rf_rdata  in  32  register-file read data, combinational from rf_raddr
- done  out  1  run finished, one-cycle pulse
- timeout  out  1  sticky flag: last run hit run_limit
- cycles  out  16  enabled-cycle count of the current or last run

Function
REQ-002 SHALL implement FSM states IDLE, WRITE, RUN, DRAIN, READ and RESP.
REQ-003 SHALL assert host_ready only in IDLE.
- A command is accepted when host_valid && host_ready.
- Nop is accepted and the FSM stays in IDLE.
REQ-004 SHALL, on an accepted write, latch host_addr/host_wdata and enter WRITE for exactly one cycle, then return to IDLE.
REQ-005 SHALL, in WRITE, drive rf_we=1, rf_waddr=latched addr, rf_wdata=latched data.
- If latched addr==0, rf_we SHALL be 0 so r0 stays zero.
REQ-006 SHALL, on an accepted run, clear cycles and timeout and enter RUN.
REQ-007 SHALL, in RUN and DRAIN:
- drive cpu_en=1;
- pass writeback through: rf_we=(wb_rd!=0), rf_waddr=wb_rd, rf_wdata=wb_data.
REQ-008 SHALL hold cpu_en=0 and pass no writeback (rf_we=0) in IDLE, WRITE, READ and RESP.
REQ-009 SHALL increment cycles by 1 on every RUN cycle, saturating at 16'hFFFF.
REQ-010 SHALL leave RUN for DRAIN when cpu_pc==halt_pc, and load a 3-bit drain counter with 4.
REQ-011 SHALL leave RUN for DRAIN with timeout set to 1 when run_limit!=0 and cycles+1==run_limit, with no halt in the same cycle.
REQ-012 SHALL give halt priority when halt and limit coincide: timeout stays 0.
REQ-013 SHALL decrement the drain counter each DRAIN cycle; when it reaches 0, return to IDLE and pulse done for one cycle.
- DRAIN therefore lasts exactly 4 cycles, with cpu_en=1 in each.
REQ-014 SHALL, on an accepted read, drive rf_raddr=host_addr in READ (one cycle) and register rf_rdata into host_rdata.
REQ-015 SHALL then enter RESP for one cycle with host_rvalid=1, then return to IDLE.
- Read latency: data valid 2 cycles after acceptance.
REQ-016 SHALL hold host_rdata stable until the next read completes.
REQ-017 SHALL ignore host_valid while host_ready=0; no command is queued.
REQ-018 SHALL hold cycles and timeout after a run until the next run command is accepted.

Reset
REQ-019 SHALL, on rst asserted, immediately (asynchronously) set:
- state IDLE;
- cpu_en, rf_we, host_rvalid, done, timeout all 0;
- cycles, host_rdata, rf_waddr, rf_wdata, rf_raddr all 0.
REQ-020 SHALL, on rst during RUN or DRAIN, drop cpu_en in the same instant with no done pulse; host_ready=1 on the first clock after release.

Verification
REQ-021 Write r5=0x1234_5678 -> one cycle with rf_we=1, rf_waddr=5, rf_wdata=0x12345678; host_ready back to 1 next cycle.
REQ-022 Write r0=0xFFFF_FFFF, then read r0 -> rf_we stays 0; host_rvalid pulse with host_rdata = rf_rdata of r0 (0).
REQ-023 Run with halt_pc=0x20 reached on the 9th RUN cycle, run_limit=0 -> cycles=9, cpu_en high for 9+4 cycles, done pulse, timeout=0.
REQ-024 Run with run_limit=3 and halt never reached -> cycles=3, timeout=1, 4 drain cycles, done pulse.
REQ-025 Halt and limit in the same cycle (run_limit=5, halt on cycle 5) -> timeout=0, done pulse.
REQ-026 rst asserted mid-RUN -> cpu_en=0 immediately, no done pulse, cycles=0, host_ready=1 after release; host_valid during RUN is never acknowledged.
